// File: rtl/shift_line_pixel_tap.sv
// Pixel-then-line delay tap chain: a short register shift followed by cascaded line buffers with valid tracking.
// Optional macro SHIFT_TAP_ZERO_FILL_EN forces each tap to zero while its valid flag is low.
module shift_line_pixel_tap #(
  parameter int P_DATA_W   = 1,
  parameter int P_LINE_LEN = 640,
  parameter int P_LINES    = 9,
  parameter int P_PIXELS   = 6
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic                            i_sof,
  input  logic [P_DATA_W-1:0]             i_data,
  output logic [(P_LINES+1)*P_DATA_W-1:0] o_tap,
  output logic [P_LINES:0]                o_tap_valid,
  output logic [P_DATA_W-1:0]             o_data,
  output logic                            o_valid
);

  localparam int D      = P_LINES * P_LINE_LEN + P_PIXELS;
  localparam int FILL_W = $clog2(D + 2);
  localparam int PTR_W  = $clog2(P_LINE_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(D + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(P_LINE_LEN - 1);

  logic [P_DATA_W-1:0] pix [P_PIXELS];
  logic [P_DATA_W-1:0] mem [P_LINES][P_LINE_LEN];
  logic [P_DATA_W-1:0] tap [P_LINES+1];
  logic [PTR_W-1:0]    ptr;
  logic [FILL_W-1:0]   fill;
  logic [P_LINES:0]    valid;

  // Storage is never cleared; the fill counter decides what is trustworthy.
  // Each line stage writes the sample leaving the previous stage at the shared pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_en) begin
      pix[0] <= i_data;
      for (int j = 1; j < P_PIXELS; j++) begin
        pix[j] <= pix[j-1];
      end
      mem[0][ptr] <= pix[P_PIXELS-1];
      for (int k = 1; k < P_LINES; k++) begin
        mem[k][ptr] <= mem[k-1][ptr];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr  <= '0;
      fill <= '0;
      for (int k = 0; k <= P_LINES; k++) begin
        tap[k] <= '0;
      end
    end else if (i_en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      if (i_sof) begin
        fill <= FILL_W'(1);
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
      tap[0] <= pix[P_PIXELS-1];
      for (int k = 1; k <= P_LINES; k++) begin
        tap[k] <= mem[k-1][ptr];
      end
    end
  end

  always_comb begin
    valid = '0;
    for (int k = 0; k <= P_LINES; k++) begin
      valid[k] = (fill >= FILL_W'(k * P_LINE_LEN + P_PIXELS + 1));
    end
  end

  always_comb begin
    o_tap = '0;
    for (int k = 0; k <= P_LINES; k++) begin
`ifdef SHIFT_TAP_ZERO_FILL_EN
      o_tap[k*P_DATA_W +: P_DATA_W] = valid[k] ? tap[k] : '0;
`else
      o_tap[k*P_DATA_W +: P_DATA_W] = tap[k];
`endif
    end
  end

  assign o_tap_valid = valid;
  assign o_data      = o_tap[P_LINES*P_DATA_W +: P_DATA_W];
  assign o_valid     = valid[P_LINES];

endmodule

// File: tb/tb_shift_line_pixel_tap.sv
// Bench for shift_line_pixel_tap (8-bit, 4-sample lines, 2 lines, 1 pixel): directed table,
// corner sequences and randomized traffic checked against a sample-history model.
module tb_shift_line_pixel_tap;

  localparam int DW = 8;
  localparam int LL = 4;
  localparam int NL = 2;
  localparam int NP = 1;
  localparam int DT = NL * LL + NP;
`ifdef SHIFT_TAP_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              sof;
  logic [DW-1:0]     data;
  logic [(NL+1)*DW-1:0] o_tap;
  logic [NL:0]       o_tap_valid;
  logic [DW-1:0]     o_data;
  logic              o_valid;

  int tests = 0;
  int fails = 0;

  shift_line_pixel_tap #(
    .P_DATA_W(DW), .P_LINE_LEN(LL), .P_LINES(NL), .P_PIXELS(NP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sof(sof), .i_data(data),
    .o_tap(o_tap), .o_tap_valid(o_tap_valid), .o_data(o_data), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  // Model: every accepted sample is kept by global index; taps are lookups at fixed distances.
  logic [DW-1:0] hist [0:8191];
  int n = 0;
  int frame_start = 1;
  int rst_base = 1;

  typedef struct {
    logic          rst_n;
    logic          en;
    logic          sof;
    logic [DW-1:0] data;
    logic [2:0]    exp_valid;
    logic [23:0]   exp_tap;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t row(logic r, logic e, logic s, logic [7:0] d, logic [2:0] v,
                               logic [7:0] t2, logic [7:0] t1, logic [7:0] t0);
    vec_t x;
    x.rst_n = r; x.en = e; x.sof = s; x.data = d; x.exp_valid = v; x.exp_tap = {t2, t1, t0};
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic [DW-1:0] d);
    rst_n = r; en = e; sof = s; data = d;
    @(posedge clk);
    if (!r) begin
      rst_base = n + 1;
      frame_start = n + 1;
    end else if (e) begin
      n++;
      hist[n] = d;
      if (s) frame_start = n;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int fill;
    int dk;
    int idx;
    logic [NL:0] ev;
    fill = (n < frame_start) ? 0 : ((n - frame_start + 1 > DT + 1) ? DT + 1 : n - frame_start + 1);
    ev = '0;
    for (int k = 0; k <= NL; k++) begin
      dk = k * LL + NP;
      idx = n - dk;
      ev[k] = (fill >= dk + 1);
      if (n < rst_base) begin
        check($sformatf("%s tap%0d", tag, k), int'(o_tap[k*DW +: DW]), 0);
      end else if (ev[k]) begin
        check($sformatf("%s tap%0d", tag, k), int'(o_tap[k*DW +: DW]), int'(hist[idx]));
      end else if (ZF) begin
        check($sformatf("%s tap%0d", tag, k), int'(o_tap[k*DW +: DW]), 0);
      end else if (idx >= rst_base) begin
        check($sformatf("%s tap%0d", tag, k), int'(o_tap[k*DW +: DW]), int'(hist[idx]));
      end
    end
    check({tag, " tap_valid"}, int'(o_tap_valid), int'(ev));
    check({tag, " valid"}, int'(o_valid), int'(ev[NL]));
    check({tag, " data=tap2"}, int'(o_data), int'(o_tap[NL*DW +: DW]));
  endtask

  initial begin
    int cnt;
    bit e;
    rst_n = 1'b0; en = 1'b0; sof = 1'b0; data = '0;

    vecs[0]  = row(0, 1, 0, 8'hAA, 3'b000, 0, 0, 0);
    vecs[1]  = row(0, 1, 0, 8'hAA, 3'b000, 0, 0, 0);
    vecs[2]  = row(0, 1, 1, 8'hAA, 3'b000, 0, 0, 0);
    vecs[3]  = row(1, 1, 1, 1,  3'b000, 0, 0, 0);
    vecs[4]  = row(1, 1, 0, 2,  3'b001, 0, 0, 1);
    vecs[5]  = row(1, 1, 0, 3,  3'b001, 0, 0, 2);
    vecs[6]  = row(1, 1, 0, 4,  3'b001, 0, 0, 3);
    vecs[7]  = row(1, 1, 0, 5,  3'b001, 0, 0, 4);
    vecs[8]  = row(1, 1, 0, 6,  3'b011, 0, 1, 5);
    vecs[9]  = row(1, 1, 0, 7,  3'b011, 0, 2, 6);
    vecs[10] = row(1, 1, 0, 8,  3'b011, 0, 3, 7);
    vecs[11] = row(1, 1, 0, 9,  3'b011, 0, 4, 8);
    vecs[12] = row(1, 1, 0, 10, 3'b111, 1, 5, 9);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].sof, vecs[i].data);
      check($sformatf("vec%0d tap_valid", i), int'(o_tap_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d valid", i), int'(o_valid), int'(vecs[i].exp_valid[2]));
      for (int k = 0; k <= NL; k++) begin
        if (!vecs[i].rst_n || vecs[i].exp_valid[k] || ZF)
          check($sformatf("vec%0d tap%0d", i, k), int'(o_tap[k*DW +: DW]),
                int'(vecs[i].exp_tap[k*8 +: 8]));
      end
    end

    // Mid-stream frame start at sample 20 on an unbroken stream spanning several lines.
    for (int d = 11; d <= 19; d++) begin
      applyStimulus(1, 1, 0, DW'(d));
      checkOutput($sformatf("stream%0d", d));
    end
    applyStimulus(1, 1, 1, 8'd20);
    check("sof20 valid", int'(o_valid), 0);
    check("sof20 data", int'(o_data), ZF ? 0 : 11);
    checkOutput("sof20");
    for (int d = 21; d <= 28; d++) begin
      applyStimulus(1, 1, 0, DW'(d));
      checkOutput($sformatf("refill%0d", d));
    end
    applyStimulus(1, 1, 0, 8'd29);
    check("s29 valid", int'(o_valid), 1);
    check("s29 data", int'(o_data), 20);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 8'hEE);
      checkOutput("idle");
    end

    // Reset mid-operation: the first enabled sample afterwards starts a frame without sof.
    applyStimulus(0, 1, 0, 8'h55);
    applyStimulus(0, 1, 1, 8'h55);
    checkOutput("rst");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, DW'(100 + i));
      checkOutput("post_rst");
    end
    check("post_rst valid", int'(o_valid), 1);
    check("post_rst data", int'(o_data), 100);

    // Same 1,2,3... stream with random enable gaps.
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 12; c++) begin
      e = 1'($urandom_range(0, 1));
      if (e) cnt++;
      applyStimulus(1, e, e && cnt == 1, e ? DW'(cnt) : DW'($urandom));
      checkOutput("gap");
      if (e && cnt == 10) begin
        check("gap10 data", int'(o_data), 1);
        check("gap10 tap1", int'(o_tap[DW +: DW]), 5);
        check("gap10 tap0", int'(o_tap[0 +: DW]), 9);
      end
    end
    check("gap stream completed", int'(cnt >= 12), 1);

    for (int c = 0; c < 500; c++) begin
      applyStimulus(($urandom % 150) != 0, 1'($urandom_range(0, 1)),
                    ($urandom % 40) == 0, DW'($urandom));
      checkOutput("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
